sawtooth_generator: RTL and testbench

Phase-accumulator sawtooth source that produces the Q0.N_FRAC counter value and its one-cycle valid strobe. These two signals drive the square pulse generator and the other waveform shapers. A programmable prescaler sets the sample rate. A programmable phase increment sets the output frequency and is applied glitch-free only on sample boundaries. A wrap strobe marks the start of each period so downstream stages can synchronise.

---
 rtl/sawtooth_generator.sv | 140 ++++++++++++++
 tb/tb_sawtooth_generator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sawtooth_generator.sv
`default_nettype none
// ============================================================================
// Module      : sawtooth_generator
// Description : Phase-accumulator sawtooth source. A programmable prescaler
//               produces sample ticks. On each tick the phase accumulator
//               advances by the active increment. The top N_FRAC+1 bits,
//               with the MSB inverted, form a signed Q0.N_FRAC sawtooth.
//               A new increment is staged in a shadow register and takes
//               effect only on a sample boundary, so the waveform never
//               glitches mid-sample.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i                        in   system clock
//   rst_i                        in   asynchronous reset, active low
//   enable_i                     in   1 = run prescaler/accumulator, 0 = hold
//   prescaler_i                  in   tick every prescaler_i+1 enabled clocks
//   increment_i                  in   new phase increment (unsigned)
//   increment_valid_strobe_i     in   capture increment_i into the shadow
//   phase_reset_strobe_i         in   synchronous restart at phase 0
//   counter_value_o              out  signed sawtooth value (Q0.N_FRAC)
//   counter_value_valid_strobe_o out  one-cycle pulse, new value present
//   wrap_strobe_o                out  one-cycle pulse, accumulator overflowed
//   increment_pending_o          out  shadow captured, not yet applied
// ============================================================================
module sawtooth_generator #(
  parameter int               N_FRAC            = 7,
  parameter int               N_ACC             = 16,
  parameter int               PRESCALER_WIDTH   = 8,
  parameter logic [N_ACC-1:0] DEFAULT_INCREMENT = 'h0100
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [PRESCALER_WIDTH-1:0] prescaler_i,
  input  logic [N_ACC-1:0]           increment_i,
  input  logic                       increment_valid_strobe_i,
  input  logic                       phase_reset_strobe_i,
  output logic [N_FRAC:0]            counter_value_o,
  output logic                       counter_value_valid_strobe_o,
  output logic                       wrap_strobe_o,
  output logic                       increment_pending_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N_ACC-1:0]           r_acc;
  logic [PRESCALER_WIDTH-1:0] r_cnt;
  logic [N_ACC-1:0]           r_active_inc;
  logic [N_ACC-1:0]           r_shadow_inc;
  logic                       r_pending;
  logic                       r_valid;
  logic                       r_wrap;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  // Using >= rather than == means a prescaler lowered below the running
  // count terminates the current period at once instead of wrapping the
  // counter around its full range.
  logic                       w_cnt_done;
  logic                       w_tick;
  logic [N_ACC:0]             w_sum;
  logic                       w_apply_shadow;

  assign w_cnt_done     = (r_cnt >= prescaler_i);
  // Phase reset wins over a coincident tick.
  assign w_tick         = enable_i & w_cnt_done & ~phase_reset_strobe_i;
  // One extra bit captures the carry that drives the wrap strobe.
  assign w_sum          = {1'b0, r_acc} + {1'b0, r_active_inc};
  assign w_apply_shadow = w_tick & r_pending;

  // --------------------------------------------------------------------------
  // Prescaler, accumulator and output strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      if (phase_reset_strobe_i) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (!enable_i) begin
        // Clearing the count here guarantees a full prescaler period
        // before the first tick after enable returns.
        r_cnt <= '0;
      end else if (w_cnt_done) begin
        r_acc   <= w_sum[N_ACC-1:0];
        r_cnt   <= '0;
        r_valid <= 1'b1;
        r_wrap  <= w_sum[N_ACC];
      end else begin
        r_cnt <= r_cnt + PRESCALER_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Increment shadow handshake
  // --------------------------------------------------------------------------
  // The tick that applies the shadow still adds the old active increment,
  // because w_sum is formed from r_active_inc before this edge updates it.
  // A load on the applying tick moves the old shadow into the active
  // register and leaves the freshly loaded value pending.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_active_inc <= DEFAULT_INCREMENT;
      r_shadow_inc <= DEFAULT_INCREMENT;
      r_pending    <= 1'b0;
    end else begin
      if (w_apply_shadow) begin
        r_active_inc <= r_shadow_inc;
      end
      if (increment_valid_strobe_i) begin
        r_shadow_inc <= increment_i;
        r_pending    <= 1'b1;
      end else if (w_apply_shadow) begin
        r_pending    <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Inverting the MSB re-centres the unsigned phase into two's complement:
  // phase 0 maps to the most negative code, full scale to 1-LSB.
  assign counter_value_o              = {~r_acc[N_ACC-1], r_acc[N_ACC-2 -: N_FRAC]};
  assign counter_value_valid_strobe_o = r_valid;
  assign wrap_strobe_o                = r_wrap;
  assign increment_pending_o          = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_sawtooth_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sawtooth_generator
// Description : Self-checking bench for sawtooth_generator. An arithmetic
//               phase model is compared against the DUT on every falling
//               clock edge; directed sequences add hand-computed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sawtooth_generator;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [7:0]  prescaler_i;
  logic [15:0] increment_i;
  logic        increment_valid_strobe_i;
  logic        phase_reset_strobe_i;
  logic [7:0]  counter_value_o;
  logic        counter_value_valid_strobe_o;
  logic        wrap_strobe_o;
  logic        increment_pending_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  always #5 clk_i = ~clk_i;

  sawtooth_generator #(
    .N_FRAC           (7),
    .N_ACC            (16),
    .PRESCALER_WIDTH  (8),
    .DEFAULT_INCREMENT(16'h0100)
  ) dut (
    .clk_i                       (clk_i),
    .rst_i                       (rst_i),
    .enable_i                    (enable_i),
    .prescaler_i                 (prescaler_i),
    .increment_i                 (increment_i),
    .increment_valid_strobe_i    (increment_valid_strobe_i),
    .phase_reset_strobe_i        (phase_reset_strobe_i),
    .counter_value_o             (counter_value_o),
    .counter_value_valid_strobe_o(counter_value_valid_strobe_o),
    .wrap_strobe_o               (wrap_strobe_o),
    .increment_pending_o         (increment_pending_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sval();
    return int'($signed(counter_value_o));
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: phase as a plain integer modulo 65536, sample count
  // as an integer, staged increment kept as value + valid flag.
  // --------------------------------------------------------------------------
  int m_phase, m_div, m_inc, m_next, m_sum;
  bit m_has_next, m_vs, m_wr, m_fire;

  always_comb begin
    m_fire = enable_i && !phase_reset_strobe_i && (m_div >= int'(prescaler_i));
    m_sum  = m_phase + m_inc;
  end

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_phase    <= 0;
      m_div      <= 0;
      m_inc      <= 256;
      m_next     <= 256;
      m_has_next <= 1'b0;
      m_vs       <= 1'b0;
      m_wr       <= 1'b0;
    end else begin
      m_vs <= 1'b0;
      m_wr <= 1'b0;
      if (phase_reset_strobe_i) begin
        m_phase <= 0;
        m_div   <= 0;
      end else if (!enable_i) begin
        m_div <= 0;
      end else if (m_fire) begin
        m_phase <= m_sum % 65536;
        m_wr    <= (m_sum >= 65536);
        m_vs    <= 1'b1;
        m_div   <= 0;
      end else begin
        m_div <= m_div + 1;
      end
      if (m_fire && m_has_next) begin
        m_inc      <= m_next;
        m_has_next <= 1'b0;
      end
      if (increment_valid_strobe_i) begin
        m_next     <= int'(increment_i);
        m_has_next <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (checking && rst_i) begin
      chk("model_value", sval(), (m_phase / 256) - 128);
      chk("model_valid", int'(counter_value_valid_strobe_o), int'(m_vs));
      chk("model_wrap", int'(wrap_strobe_o), int'(m_wr));
      chk("model_pending", int'(increment_pending_o), int'(m_has_next));
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_strobe();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (counter_value_valid_strobe_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("strobe_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i                    = 1'b0;
    enable_i                 = 1'b0;
    prescaler_i              = 8'd0;
    increment_i              = 16'h0000;
    increment_valid_strobe_i = 1'b0;
    phase_reset_strobe_i     = 1'b0;
    cyc(); cyc(); cyc();
    rst_i    = 1'b1;
    checking = 1'b1;
    chk("reset_value", sval(), -128);
    chk("reset_valid", int'(counter_value_valid_strobe_o), 0);
    chk("reset_wrap", int'(wrap_strobe_o), 0);
    chk("reset_pending", int'(increment_pending_o), 0);

    // Full period at one tick per clock.
    enable_i = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      cyc();
      if (i == 1) begin
        chk("p0_first_value", sval(), -127);
        chk("p0_first_valid", int'(counter_value_valid_strobe_o), 1);
      end
      if (i == 255) begin
        chk("p0_last_value", sval(), 127);
        chk("p0_last_wrap", int'(wrap_strobe_o), 0);
      end
      if (i == 256) begin
        chk("p0_wrap_value", sval(), -128);
        chk("p0_wrap_strobe", int'(wrap_strobe_o), 1);
      end
    end

    // Prescaler 3: first strobe four clocks after enable.
    enable_i = 1'b0;
    phase_reset_strobe_i = 1'b1;
    prescaler_i = 8'd3;
    cyc();
    phase_reset_strobe_i = 1'b0;
    enable_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("p3_valid", int'(counter_value_valid_strobe_o), (i == 4) ? 1 : 0);
    end
    chk("p3_first_value", sval(), -127);
    wait_strobe();
    wait_strobe();
    chk("p3_third_value", sval(), -125);

    // Load 0x8000 mid-run.
    increment_i = 16'h8000;
    increment_valid_strobe_i = 1'b1;
    cyc();
    increment_valid_strobe_i = 1'b0;
    chk("load_pending", int'(increment_pending_o), 1);
    wait_strobe();
    chk("load_old_inc_value", sval(), -124);
    chk("load_applied_pending", int'(increment_pending_o), 0);
    wait_strobe();
    chk("half_step_value", sval(), 4);
    chk("half_step_wrap", int'(wrap_strobe_o), 0);
    wait_strobe();
    chk("half_wrap_value", sval(), -124);
    chk("half_wrap_strobe", int'(wrap_strobe_o), 1);

    // Hold for ten cycles, then resume with a full prescaler period.
    enable_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_valid", int'(counter_value_valid_strobe_o), 0);
      chk("hold_value", sval(), -124);
    end
    enable_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("resume_valid", int'(counter_value_valid_strobe_o), (i == 4) ? 1 : 0);
    end
    chk("resume_value", sval(), 4);

    // Restore 0x0100, then phase reset coincident with a tick at 0x4000.
    increment_i = 16'h0100;
    increment_valid_strobe_i = 1'b1;
    cyc();
    increment_valid_strobe_i = 1'b0;
    wait_strobe();
    chk("restore_value", sval(), -124);
    prescaler_i = 8'd0;
    phase_reset_strobe_i = 1'b1;
    cyc();
    phase_reset_strobe_i = 1'b0;
    chk("preset0_value", sval(), -128);
    chk("preset0_valid", int'(counter_value_valid_strobe_o), 0);
    for (int i = 0; i < 64; i++) cyc();
    chk("quarter_value", sval(), -64);
    phase_reset_strobe_i = 1'b1;
    cyc();
    phase_reset_strobe_i = 1'b0;
    chk("preset_tick_value", sval(), -128);
    chk("preset_tick_valid", int'(counter_value_valid_strobe_o), 0);
    chk("preset_tick_wrap", int'(wrap_strobe_o), 0);
    cyc();
    chk("after_preset_value", sval(), -127);
    chk("after_preset_valid", int'(counter_value_valid_strobe_o), 1);

    // Asynchronous reset between clock edges with a pending increment.
    prescaler_i = 8'd5;
    increment_i = 16'h1234;
    increment_valid_strobe_i = 1'b1;
    cyc();
    increment_valid_strobe_i = 1'b0;
    chk("pre_reset_pending", int'(increment_pending_o), 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_value", sval(), -128);
    chk("async_valid", int'(counter_value_valid_strobe_o), 0);
    chk("async_wrap", int'(wrap_strobe_o), 0);
    chk("async_pending", int'(increment_pending_o), 0);
    cyc(); cyc();
    prescaler_i = 8'd0;
    rst_i = 1'b1;
    cyc();
    chk("fresh_first_value", sval(), -127);
    chk("fresh_first_valid", int'(counter_value_valid_strobe_o), 1);
    cyc();
    chk("fresh_second_value", sval(), -126);
    for (int i = 0; i < 8; i++) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
